// File: rtl/cmac_tx_pkg.sv
// ============================================================================
//  Module      : cmac_tx_pkg
//  Description : Shared definitions for the CMAC TX AXI4-Stream arbiter:
//                arbiter FSM state encoding, source identifiers and default
//                stream widths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmac_tx_pkg;

  // Arbiter FSM states, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

  // Source identifiers, also the encoding of grant_id.
  localparam logic SRC_ERNIC  = 1'b0;
  localparam logic SRC_PKTGEN = 1'b1;

  // Default CMAC TX stream widths (512-bit segment, one keep bit per byte).
  localparam int DEF_DATA_W = 512;
  localparam int DEF_KEEP_W = DEF_DATA_W / 8;

endpackage : cmac_tx_pkg

`default_nettype wire

// File: rtl/cmac_tx_axis_arb.sv
// ============================================================================
//  Module      : cmac_tx_axis_arb
//  Description : Packet-level round-robin arbiter sharing the CMAC TX
//                AXI4-Stream port between the ERNIC transmit stream (s0)
//                and the test packet generator (s1). A grant is held for a
//                whole packet; new grants are only issued while link_en is
//                high. Per-source completed-packet counters are provided.
//  Revision    : 1.0 - initial release
//
//  Ports
//    aclk, aresetn        : txusrclk2 clock, asynchronous active-low reset
//    link_en              : link aligned and TX enabled; gates new grants
//    s0_axis_*            : source 0 (ERNIC) stream in, s0_axis_tready out
//    s1_axis_*            : source 1 (packet generator) stream in, tready out
//    m_axis_*             : stream to the CMAC core, m_axis_tready in
//    busy                 : a packet transfer is in progress
//    grant_id             : source currently or most recently granted
//    pkt_cnt0, pkt_cnt1   : packets completed per source (wrapping)
// ============================================================================
`default_nettype none

module cmac_tx_axis_arb
  import cmac_tx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int KEEP_W = DATA_W / 8,
  parameter int CNT_W  = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              link_en,

  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic [KEEP_W-1:0] s0_axis_tkeep,
  input  logic              s0_axis_tvalid,
  input  logic              s0_axis_tlast,
  input  logic              s0_axis_tuser,
  output logic              s0_axis_tready,

  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic [KEEP_W-1:0] s1_axis_tkeep,
  input  logic              s1_axis_tvalid,
  input  logic              s1_axis_tlast,
  input  logic              s1_axis_tuser,
  output logic              s1_axis_tready,

  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  input  logic              m_axis_tready,

  output logic              busy,
  output logic              grant_id,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_grant;
  logic             r_prio;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_req_any;
  logic             w_arb_win;
  logic             w_pkt_done;

  // --------------------------------------------------------------------------
  // Arbitration decision. With both sources requesting, the round-robin
  // pointer decides; a lone requester always wins.
  // --------------------------------------------------------------------------
  always_comb begin
    w_req_any = s0_axis_tvalid | s1_axis_tvalid;
    w_arb_win = SRC_ERNIC;
    if (s0_axis_tvalid && s1_axis_tvalid) begin
      w_arb_win = r_prio;
    end else if (s1_axis_tvalid) begin
      w_arb_win = SRC_PKTGEN;
    end
  end

  // --------------------------------------------------------------------------
  // Combinational 2:1 stream mux. Outside XFER everything is forced low so
  // no source sees a ready and the CMAC sees no valid.
  // --------------------------------------------------------------------------
  always_comb begin
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    if (r_state == XFER) begin
      if (r_grant == SRC_PKTGEN) begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        m_axis_tuser   = s1_axis_tuser;
        s1_axis_tready = m_axis_tready;
      end else begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        m_axis_tuser   = s0_axis_tuser;
        s0_axis_tready = m_axis_tready;
      end
    end
  end

  // Final beat of the granted packet accepted by the CMAC.
  assign w_pkt_done = (r_state == XFER) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // --------------------------------------------------------------------------
  // Next-state logic. link_en is only consulted in IDLE so a packet already
  // granted always runs to completion.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (link_en && w_req_any) begin
          w_state_nxt = ARB;
        end
      end
      ARB: begin
        // A requester that withdrew tvalid is tolerated by falling back.
        if (w_req_any) begin
          w_state_nxt = XFER;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      XFER: begin
        if (w_pkt_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Grant, round-robin pointer and packet counters.
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_grant <= SRC_ERNIC;
      r_prio  <= SRC_ERNIC;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      if ((r_state == ARB) && w_req_any) begin
        r_grant <= w_arb_win;
      end
      if (w_pkt_done) begin
        // Hand priority to the source that was not just served.
        r_prio <= ~r_grant;
        if (r_grant == SRC_PKTGEN) begin
          r_cnt1 <= r_cnt1 + c_cnt_one;
        end else begin
          r_cnt0 <= r_cnt0 + c_cnt_one;
        end
      end
    end
  end

  assign busy     = (r_state == XFER);
  assign grant_id = r_grant;
  assign pkt_cnt0 = r_cnt0;
  assign pkt_cnt1 = r_cnt1;

endmodule : cmac_tx_axis_arb

`default_nettype wire

// File: tb/tb_cmac_tx_axis_arb.sv
// ============================================================================
//  Module      : tb_cmac_tx_axis_arb
//  Description : Directed self-checking bench for cmac_tx_axis_arb. Each
//                source is fed from a beat queue that advances on handshake;
//                accepted m_axis beats are logged with grant and cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmac_tx_axis_arb;

  localparam int DW = 512;
  localparam int KW = 64;
  localparam int CW = 4;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          link_en;
  logic [DW-1:0] s0_axis_tdata,  s1_axis_tdata,  m_axis_tdata;
  logic [KW-1:0] s0_axis_tkeep,  s1_axis_tkeep,  m_axis_tkeep;
  logic          s0_axis_tvalid, s1_axis_tvalid, m_axis_tvalid;
  logic          s0_axis_tlast,  s1_axis_tlast,  m_axis_tlast;
  logic          s0_axis_tuser,  s1_axis_tuser,  m_axis_tuser;
  logic          s0_axis_tready, s1_axis_tready, m_axis_tready;
  logic          busy;
  logic          grant_id;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;

  cmac_tx_axis_arb #(.DATA_W(DW), .KEEP_W(KW), .CNT_W(CW)) dut (
    .aclk(aclk), .aresetn(aresetn), .link_en(link_en),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tlast(s0_axis_tlast),
    .s0_axis_tuser(s0_axis_tuser), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tlast(s1_axis_tlast),
    .s1_axis_tuser(s1_axis_tuser), .s1_axis_tready(s1_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .busy(busy), .grant_id(grant_id), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
  } beat_t;

  typedef struct {
    beat_t b;
    logic  g;
    int    c;
  } mbeat_t;

  beat_t  q0[$];
  beat_t  q1[$];
  mbeat_t mon[$];
  int     cyc;
  int     n_pass, n_tot, n_fail;

  // Beat payload: 32-bit word {src, pkt, beat} replicated across the bus.
  function automatic beat_t mk(input int src, input int pkt, input int beat,
                               input int nb, input logic [KW-1:0] lk);
    beat_t       b;
    logic [31:0] w;
    w   = {8'(src), 8'(pkt), 16'(beat)};
    b.d = {16{w}};
    b.l = (beat == nb - 1);
    b.k = b.l ? lk : '1;
    b.u = (beat == 0);
    return b;
  endfunction

  task automatic push(input int src, input int pkt, input int nb, input logic [KW-1:0] lk);
    for (int i = 0; i < nb; i++) begin
      if (src == 0) q0.push_back(mk(src, pkt, i, nb, lk));
      else          q1.push_back(mk(src, pkt, i, nb, lk));
    end
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_beats(input int n, input string tag);
    int k;
    k = 0;
    while (mon.size() < n && k < 3000) begin
      @(posedge aclk); #2;
      k++;
    end
    chk(tag, 512'(mon.size()), 512'(n));
  endtask

  task automatic chk_beat(input string tag, input int i, input beat_t e, input logic g);
    if (i < mon.size()) begin
      chk($sformatf("%s_data%0d", tag, i), 512'(mon[i].b.d), 512'(e.d));
      chk($sformatf("%s_ctl%0d", tag, i), 512'({mon[i].b.k, mon[i].b.l, mon[i].b.u}), 512'({e.k, e.l, e.u}));
      chk($sformatf("%s_gnt%0d", tag, i), 512'(mon[i].g), 512'(g));
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_s0rdy"}, 512'(s0_axis_tready), 512'(0));
    chk({tag, "_s1rdy"}, 512'(s1_axis_tready), 512'(0));
    chk({tag, "_mvalid"}, 512'(m_axis_tvalid), 512'(0));
    chk({tag, "_mlast"}, 512'(m_axis_tlast), 512'(0));
    chk({tag, "_muser"}, 512'(m_axis_tuser), 512'(0));
    chk({tag, "_mdata"}, 512'(m_axis_tdata), 512'(0));
    chk({tag, "_mkeep"}, 512'(m_axis_tkeep), 512'(0));
    chk({tag, "_busy"}, 512'(busy), 512'(0));
    chk({tag, "_grant"}, 512'(grant_id), 512'(0));
    chk({tag, "_cnt0"}, 512'(pkt_cnt0), 512'(0));
    chk({tag, "_cnt1"}, 512'(pkt_cnt1), 512'(0));
  endtask

  // Cycle counter; value seen between edges identifies the current cycle.
  initial begin
    cyc = 0;
    forever begin
      @(posedge aclk);
      cyc++;
    end
  end

  // Source 0 driver: hold the head beat until it is accepted.
  initial begin : feed0
    logic fire;
    s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tkeep = '0;
    s0_axis_tlast = 1'b0;  s0_axis_tuser = 1'b0;
    forever begin
      @(negedge aclk);
      fire = s0_axis_tvalid && s0_axis_tready;
      @(posedge aclk); #1;
      if (fire && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
        s0_axis_tvalid = 1'b1;    s0_axis_tdata = q0[0].d; s0_axis_tkeep = q0[0].k;
        s0_axis_tlast = q0[0].l;  s0_axis_tuser = q0[0].u;
      end else begin
        s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tkeep = '0;
        s0_axis_tlast = 1'b0;  s0_axis_tuser = 1'b0;
      end
    end
  end

  // Source 1 driver.
  initial begin : feed1
    logic fire;
    s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tkeep = '0;
    s1_axis_tlast = 1'b0;  s1_axis_tuser = 1'b0;
    forever begin
      @(negedge aclk);
      fire = s1_axis_tvalid && s1_axis_tready;
      @(posedge aclk); #1;
      if (fire && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
        s1_axis_tvalid = 1'b1;    s1_axis_tdata = q1[0].d; s1_axis_tkeep = q1[0].k;
        s1_axis_tlast = q1[0].l;  s1_axis_tuser = q1[0].u;
      end else begin
        s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tkeep = '0;
        s1_axis_tlast = 1'b0;  s1_axis_tuser = 1'b0;
      end
    end
  end

  // Log every beat accepted on m_axis.
  initial begin : monitor
    mbeat_t e;
    forever begin
      @(negedge aclk);
      if (m_axis_tvalid && m_axis_tready) begin
        e.b = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        e.g = grant_id;
        e.c = cyc;
        mon.push_back(e);
      end
    end
  end

  initial begin : stim
    int k, hi1, c0, r, n0;
    n_pass = 0; n_tot = 0; n_fail = 0;
    aresetn = 1'b0; link_en = 1'b0; m_axis_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #2;

    // ---- reset state ----
    chk_idle_outputs("rst");
    aresetn = 1'b1; link_en = 1'b1; m_axis_tready = 1'b1;

    // ---- single source: three 9-beat s1 packets ----
    @(posedge aclk); #2;
    mon.delete();
    c0 = cyc;
    for (int p = 0; p < 3; p++) push(1, p, 9, 64'h3FF);
    wait_beats(27, "t1_beats");
    for (int i = 0; i < 27; i++) chk_beat("t1", i, mk(1, i / 9, i % 9, 9, 64'h3FF), 1'b1);
    if (mon.size() >= 27) begin
      chk("t1_latency", 512'(mon[0].c - c0), 512'(3));
      chk("t1_gap1", 512'(mon[9].c - mon[8].c), 512'(3));
      chk("t1_gap2", 512'(mon[18].c - mon[17].c), 512'(3));
    end
    chk("t1_cnt1", 512'(pkt_cnt1), 512'(3));
    chk("t1_cnt0", 512'(pkt_cnt0), 512'(0));
    chk("t1_busy", 512'(busy), 512'(0));

    // ---- contention: both sources loaded before reset release ----
    aresetn = 1'b0;
    q0.delete(); q1.delete();
    for (int p = 0; p < 4; p++) begin
      push(0, p, 4, '1);
      push(1, p, 4, '1);
    end
    repeat (2) begin @(posedge aclk); #2; end
    mon.delete();
    aresetn = 1'b1;
    wait_beats(32, "t2_beats");
    for (int i = 0; i < 32; i++) chk_beat("t2", i, mk((i / 4) % 2, i / 8, i % 4, 4, '1), 1'((i / 4) % 2));
    chk("t2_cnt0", 512'(pkt_cnt0), 512'(4));
    chk("t2_cnt1", 512'(pkt_cnt1), 512'(4));

    // ---- backpressure: m_tready toggles during a 5-beat s0 packet ----
    mon.delete();
    push(0, 10, 5, '1);
    push(1, 10, 3, '1);
    m_axis_tready = 1'b0;
    hi1 = 0; k = 0;
    while (mon.size() < 5 && k < 200) begin
      @(posedge aclk); #2;
      if (s1_axis_tready) hi1++;
      m_axis_tready = ~m_axis_tready;
      k++;
    end
    chk("t3_s1rdy_low", 512'(hi1), 512'(0));
    m_axis_tready = 1'b1;
    wait_beats(8, "t3_beats");
    for (int i = 0; i < 5; i++) chk_beat("t3", i, mk(0, 10, i, 5, '1), 1'b0);
    chk_beat("t3", 5, mk(1, 10, 0, 3, '1), 1'b1);
    n0 = 0;
    foreach (mon[i]) if (mon[i].g == 1'b0) n0++;
    chk("t3_s0_beat_count", 512'(n0), 512'(5));
    chk("t3_cnt0", 512'(pkt_cnt0), 512'(5));
    chk("t3_cnt1", 512'(pkt_cnt1), 512'(5));

    // ---- link_en drop during beat 2 of a 6-beat s0 packet ----
    mon.delete();
    push(0, 20, 6, '1);
    k = 0;
    while (mon.size() < 1 && k < 100) begin @(posedge aclk); #2; k++; end
    link_en = 1'b0;
    push(1, 20, 3, '1);
    wait_beats(6, "t4_s0_beats");
    repeat (8) begin @(posedge aclk); #2; end
    chk("t4_no_grant", 512'(mon.size()), 512'(6));
    chk("t4_busy", 512'(busy), 512'(0));
    r = cyc;
    link_en = 1'b1;
    wait_beats(9, "t4_all_beats");
    for (int i = 0; i < 6; i++) chk_beat("t4a", i, mk(0, 20, i, 6, '1), 1'b0);
    for (int i = 0; i < 3; i++) chk_beat("t4b", 6 + i, mk(1, 20, i, 3, '1), 1'b1);
    if (mon.size() >= 9) chk("t4_resume_lat", 512'(mon[6].c - r), 512'(2));
    chk("t4_cnt0", 512'(pkt_cnt0), 512'(6));
    chk("t4_cnt1", 512'(pkt_cnt1), 512'(6));

    // ---- reset mid-packet (priority left pointing at source 1) ----
    mon.delete();
    push(0, 30, 1, '1);
    wait_beats(1, "t5_pre");
    push(1, 30, 5, '1);
    k = 0;
    while (mon.size() < 3 && k < 100) begin @(posedge aclk); #2; k++; end
    aresetn = 1'b0;
    q0.delete(); q1.delete();
    @(posedge aclk); #2;
    chk_idle_outputs("t5_rst");
    chk("t5_no_extra_beat", 512'(mon.size()), 512'(3));
    aresetn = 1'b1;
    mon.delete();
    push(0, 31, 1, '1);
    push(1, 31, 1, '1);
    wait_beats(2, "t5_beats");
    chk_beat("t5", 0, mk(0, 31, 0, 1, '1), 1'b0);
    chk_beat("t5", 1, mk(1, 31, 0, 1, '1), 1'b1);
    chk("t5_cnt0", 512'(pkt_cnt0), 512'(1));
    chk("t5_cnt1", 512'(pkt_cnt1), 512'(1));

    // ---- counter wrap: 17 single-beat s0 packets with a 4-bit counter ----
    aresetn = 1'b0;
    @(posedge aclk); #2;
    mon.delete();
    aresetn = 1'b1;
    for (int p = 0; p < 17; p++) push(0, p, 1, '1);
    wait_beats(17, "t6_beats");
    chk_beat("t6", 16, mk(0, 16, 0, 1, '1), 1'b0);
    chk("t6_cnt0_wrap", 512'(pkt_cnt0), 512'(1));
    chk("t6_cnt1", 512'(pkt_cnt1), 512'(0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule : tb_cmac_tx_axis_arb

`default_nettype wire

// File: doc/cmac_tx_axis_arb.md
# cmac_tx_axis_arb

Packet-level round-robin arbiter sharing the single CMAC TX AXI4-Stream port (512-bit, txusrclk2 domain) between two requesters: the ERNIC transmit stream (source 0) and the test packet generator (source 1). Sits between those sources and the CMAC core `tx_axis_*` inputs. It locks a grant for a whole packet, gates new grants on link readiness, and keeps per-source packet counters for status readout.

## Interface
Parameters:
- DATA_W, 512, tdata width
- KEEP_W, 64, tkeep width (DATA_W/8)
- CNT_W, 32, width of packet counters

Ports:
- aclk  in  1  clock (CMAC txusrclk2)
- aresetn  in  1  asynchronous, active-low reset
- link_en  in  1  high when ctl_tx_enable is asserted and the link is aligned; gates new grants only
- s0_axis_tdata/tkeep/tvalid/tlast/tuser  in  DATA_W/KEEP_W/1/1/1  source 0 (ERNIC) stream
- s0_axis_tready  out  1  source 0 ready
- s1_axis_tdata/tkeep/tvalid/tlast/tuser  in  DATA_W/KEEP_W/1/1/1  source 1 (packet generator) stream
- s1_axis_tready  out  1  source 1 ready
- m_axis_tdata/tkeep/tvalid/tlast/tuser  out  DATA_W/KEEP_W/1/1/1  to CMAC tx_axis
- m_axis_tready  in  1  from CMAC tx_axis_tready
- busy  out  1  a packet is in progress
- grant_id  out  1  source currently or last granted
- pkt_cnt0, pkt_cnt1  out  CNT_W  packets completed per source

## Operation
- FSM states: IDLE, ARB, XFER.
- IDLE: all readies 0, m_axis_tvalid 0. If link_en && (s0_tvalid || s1_tvalid), go to ARB.
- ARB (one cycle): pick the winner. With one requester, it wins. With both, the source with priority wins. The priority pointer `prio` resets to 0 and, after each completed packet, points to the source that was not just served. Register grant_id. Go to XFER. If no requester is still valid in ARB (a source dropped tvalid, which is an AXIS violation but must be tolerated), return to IDLE.
- XFER:
  - m_axis_* is a combinational mux of the granted source.
  - granted sN_tready = m_axis_tready; non-granted ready = 0.
  - On a beat with m_axis_tvalid && m_axis_tready && m_axis_tlast: pkt_cntN += 1, prio = ~grant_id, go to IDLE.
- link_en deassertion during XFER never truncates a packet: the transfer completes, then no new grant is issued until link_en returns.
- tkeep and tuser pass through unmodified. The block performs no data buffering.
- Counters wrap modulo 2^CNT_W with no saturation.
- busy = (state == XFER).

## Timing
- Reset values: all tready 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tuser 0, m_axis_tdata/tkeep 0, busy 0, grant_id 0, prio 0, pkt_cnt0/1 0, state IDLE.
- Arbitration latency: a request seen in IDLE at cycle t reaches ARB at t+1. The first beat may transfer at t+2.
- Packet gap: the tlast beat is at cycle t. IDLE is at t+1, ARB at t+2, and the next first beat at t+3. That is a fixed 2-cycle bubble.
- Data path from granted source to m_axis is zero-latency combinational. No tready→tready register.
- AXIS rules: the block never drops or duplicates a beat. m_axis_tvalid follows the source; a stall on m_axis_tready holds the source.
- Reset asserted mid-packet clears state immediately. Sources must also be reset. No partial-packet recovery.
- A one-beat packet (tvalid and tlast together) is a legal full packet: pkt_cnt increments by 1.

## Structure
- Shared package `cmac_tx_pkg`: state enum (IDLE/ARB/XFER), source-id constants SRC_ERNIC=0 and SRC_PKTGEN=1, and default DATA_W/KEEP_W.
- Single flat module, no sub-module. The 2:1 mux is inline.
- Top-level integration: s0 connects to the ERNIC exdes stream, s1 to the pkt_gen AXIS output, and m to the CMAC core.

## Test plan
- Single source: s1 sends 3 packets of 9 beats (tlast with tkeep=64'h3FF on the last beat), m_tready=1 → 27 beats out in order, bubble of 2 cycles between packets, pkt_cnt1=3, pkt_cnt0=0.
- Contention: both sources present 4-beat packets continuously from reset → grant order 0,1,0,1; after 8 packets, pkt_cnt0=pkt_cnt1=4.
- Backpressure: m_tready toggles 1010… during a 5-beat packet → exactly 5 beats accepted, data matches, the non-granted source's tready stays 0 throughout.
- link_en drop: deassert link_en on beat 2 of a 6-beat s0 packet → all 6 beats complete. A pending s1 packet gets no grant until link_en rises, then goes out 2 cycles after that rise.
- Reset mid-packet: assert aresetn=0 on beat 3 → next cycle all outputs are at reset values, counters 0. After release, the first packet is granted to source 0.
- Wrap: CNT_W=4, send 17 single-beat s0 packets → pkt_cnt0=1.
